// File: rtl/seg_scan_decoder_pkg.sv
// ============================================================================
//  Module      : seg_scan_decoder_pkg
//  Description : Shared FSM encoding, counter width and 7-segment code table
//                for the multiplexed display scan decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_scan_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam int CNT_W = 8;

    // Segment order g..a in bits 6:0, active-high.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h67;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage : seg_scan_decoder_pkg

`default_nettype wire

// File: rtl/seg_scan_decoder_seg7_to_bcd.sv
// ============================================================================
//  Module      : seg7_to_bcd
//  Description : Combinational 7-segment pattern to BCD lookup. Unknown
//                patterns return 4'hF, blank returns 0 with is_blank set.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_to_bcd
    import seg_scan_decoder_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       is_digit,
    output logic       is_blank
);

    always_comb begin
        bcd      = 4'hF;
        is_digit = 1'b1;
        is_blank = 1'b0;
        case (seg)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: begin
                bcd      = 4'd0;
                is_digit = 1'b0;
                is_blank = 1'b1;
            end
            default:   is_digit = 1'b0;
        endcase
    end

endmodule : seg7_to_bcd

`default_nettype wire

// File: rtl/seg_scan_decoder.sv
// ============================================================================
//  Module      : seg_scan_decoder
//  Description : Snoops a multiplexed 8-digit 7-segment bus, debounces each
//                digit/segment pattern and captures it as BCD per digit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_decoder
    import seg_scan_decoder_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic [7:0]  seg_com,
    input  logic [7:0]  seg_data,
    output logic [31:0] digit_bcd,
    output logic [7:0]  digit_valid,
    output logic [7:0]  dp,
    output logic        upd,
    output logic [2:0]  upd_idx,
    output logic        err
);

    localparam logic [CNT_W-1:0] C_STABLE  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    logic [7:0]       r_com;
    logic [7:0]       r_data;
    logic [7:0]       r_last_com;
    logic [7:0]       r_last_data;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_capture;
    logic             w_same;
    logic             w_idle;
    logic [7:0]       w_sel;
    logic             w_one_sel;
    logic [2:0]       w_idx;
    logic [3:0]       w_nib;
    logic             w_is_digit;
    logic             w_is_blank;

    logic [31:0]      r_bcd;
    logic [7:0]       r_valid;
    logic [7:0]       r_dp;
    logic             r_upd;
    logic [2:0]       r_idx;
    logic             r_err;

    // Two-deep sample pipe: stability is judged between consecutive
    // registered samples, never against the raw pins.
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            r_com       <= 8'hFF;
            r_data      <= 8'h00;
            r_last_com  <= 8'hFF;
            r_last_data <= 8'h00;
        end else begin
            r_com       <= seg_com;
            r_data      <= seg_data;
            r_last_com  <= r_com;
            r_last_data <= r_data;
        end
    end

    assign w_same    = (r_com == r_last_com) && (r_data == r_last_data);
    assign w_idle    = (r_com == 8'hFF);
    assign w_cnt_inc = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        if (!w_same) begin
            w_cnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
            w_state_nxt = w_idle ? ST_IDLE : ST_SETTLE;
        end else if (w_idle) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = w_cnt_inc;
        end else begin
            case (r_state)
                ST_HOLD: w_cnt_nxt = w_cnt_inc;
                default: begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == C_STABLE) begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end
                end
            endcase
        end
    end

    // Exactly one low bit in the select: inverted word is a power of two.
    assign w_sel     = ~r_com;
    assign w_one_sel = (w_sel != 8'd0) && ((w_sel & (w_sel - 8'd1)) == 8'd0);

    always_comb begin
        w_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!r_com[i]) begin
                w_idx = 3'(i);
            end
        end
    end

    seg7_to_bcd u_seg7_to_bcd (
        .seg      (r_data[6:0]),
        .bcd      (w_nib),
        .is_digit (w_is_digit),
        .is_blank (w_is_blank)
    );

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            r_bcd   <= 32'd0;
            r_valid <= 8'd0;
            r_dp    <= 8'd0;
            r_upd   <= 1'b0;
            r_idx   <= 3'd0;
            r_err   <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            r_err <= 1'b0;
            if (w_capture) begin
                if (w_one_sel) begin
                    r_bcd[{w_idx, 2'b00} +: 4] <= w_nib;
                    r_valid[w_idx]             <= w_is_digit;
                    r_dp[w_idx]                <= r_data[7];
                    r_upd                      <= 1'b1;
                    r_idx                      <= w_idx;
                    r_err                      <= !(w_is_digit || w_is_blank);
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign digit_bcd   = r_bcd;
    assign digit_valid = r_valid;
    assign dp          = r_dp;
    assign upd         = r_upd;
    assign upd_idx     = r_idx;
    assign err         = r_err;

endmodule : seg_scan_decoder

`default_nettype wire

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, range 2..255: consecutive identical samples required before a digit is captured.
REQ-002 mclk  input  1  sole clock, rising-edge active.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 seg_com  input  8  digit select, active-low; bit i = 0 selects digit i.
REQ-005 seg_data  input  8  segments, active-high; bit7 = dp, bits6:0 = g..a.
REQ-006 digit_bcd  output  32  decoded BCD, digit i at bits [4i+3:4i].
REQ-007 digit_valid  output  8  bit i = 1 when digit i holds a decimal value.
REQ-008 dp  output  8  captured decimal-point state per digit.
REQ-009 upd  output  1  one-cycle pulse on each capture.
REQ-010 upd_idx  output  3  index of the captured digit; meaningful only while upd = 1.
REQ-011 err  output  1  one-cycle pulse on an illegal stable pattern or illegal select.

Function
REQ-012 {seg_com, seg_data} SHALL be registered once per mclk (sample register); all decisions use registered values.
REQ-013 FSM states: IDLE (no digit selected), SETTLE (counting equal samples), HOLD (captured, waiting for change).
REQ-014 A sample with seg_com = 8'hFF SHALL force IDLE with no capture and no err.
REQ-015 A sample differing from the previous sample SHALL reset the stability count to 1 and enter SETTLE, or IDLE if seg_com = 8'hFF.
REQ-016 In SETTLE, each equal sample increments the count; when the count reaches STABLE_CYCLES the block SHALL capture in that cycle and enter HOLD.
REQ-017 In HOLD, equal samples SHALL NOT recapture; the count saturates.
REQ-018 Capture with exactly one zero bit in seg_com: bits6:0 decode 3F,06,5B,4F,66,6D,7D,07,7F,67 -> 0..9; write nibble and dp[i]=seg_data[7], set digit_valid[i], pulse upd with upd_idx = i.
REQ-019 Capture with bits6:0 = 00 (blank): nibble = 0, digit_valid[i] = 0, dp[i] written, upd pulses, no err.
REQ-020 Capture with any other segment code: nibble = 4'hF, digit_valid[i] = 0, dp[i] written, upd and err pulse together.
REQ-021 Capture with more than one zero bit in seg_com: no digit written, upd = 0, err pulses once.
REQ-022 Outputs SHALL be registered; a capture is visible the cycle after the deciding sample, i.e. STABLE_CYCLES+1 cycles after the inputs settle.
REQ-023 Other digits' nibble, valid and dp SHALL hold unchanged across any capture.
REQ-024 upd and err SHALL be 0 in every cycle except a capture cycle.

Reset
REQ-025 While rst = 0: state = IDLE, count = 0, sample register = {8'hFF, 8'h00}, digit_bcd = 0, digit_valid = 0, dp = 0, upd = 0, err = 0, upd_idx = 0.
REQ-026 Reset asserted mid-SETTLE SHALL discard the partial count; after release a full STABLE_CYCLES of equal samples is required.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding, the ten segment-code constants (matching the team's encoder table), and SEG_BLANK = 7'h00.
REQ-028 One sub-module, seg7_to_bcd, SHALL perform the combinational segment-to-BCD lookup with outputs bcd[3:0], is_digit and is_blank.
REQ-029 The one-hot-low check on seg_com SHALL live in the top module.

Verification
REQ-030 seg_com = 8'h7F, seg_data = 8'h4F held 6 cycles -> single upd with upd_idx = 7, digit_bcd[31:28] = 3, digit_valid[7] = 1, dp[7] = 0.
REQ-031 Scan digits 0..7 with codes for 0..7, each held 5 cycles, dp set on digit 2 -> digit_bcd = 32'h76543210, digit_valid = 8'hFF, dp = 8'h04, eight upd pulses.
REQ-032 seg_data = 8'h4F for 3 cycles, then 8'h06 for 4 cycles on digit 0 (STABLE_CYCLES = 4) -> exactly one capture, value 1.
REQ-033 seg_com = 8'hFE, seg_data = 8'h49 held -> err and upd pulse once, nibble 0 = F, digit_valid[0] = 0; then seg_com = 8'hFC held -> one err, no upd, digit 0 unchanged.
REQ-034 seg_com = 8'hFF for 20 cycles -> no upd, no err, outputs unchanged.
REQ-035 Reset asserted after 2 equal samples, released, pattern held -> capture exactly STABLE_CYCLES samples after release; all outputs read 0 during reset.
